// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forward codes, register zero.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hazardStateT;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the internal bubble/flush down-counter; covers up to 15 remaining cycles.
  localparam int DOWN_W = 4;

endpackage

// File: rtl/hazard_control_unit_fwd_select.sv
// Forwarding select for one EX source operand; the younger MEM result beats the older WB result.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] exSrc,
  input  logic       memRegWrite,
  input  logic [4:0] memRd,
  input  logic       wbRegWrite,
  input  logic [4:0] wbRd,
  output logic [1:0] fwdSel
);

  // Pick the most recent in-flight producer of exSrc; register zero is never forwarded.
  always_comb begin
    fwdSel = FWD_REG;
    if (memRegWrite && (memRd != REG_ZERO) && (memRd == exSrc)) begin
      fwdSel = FWD_MEM;
    end else if (wbRegWrite && (wbRd != REG_ZERO) && (wbRd == exSrc)) begin
      fwdSel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller: forwarding selects, load-use stalls, taken-branch flushes and event counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_usesRt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch,
  input  logic             zeroEx,
  input  logic             mem_regWrite,
  input  logic [4:0]       mem_rd,
  input  logic             wb_regWrite,
  input  logic [4:0]       wb_rd,
  output logic [1:0]       saidaAfw,
  output logic [1:0]       saidaBfw,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic             pcSrc,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  hazardStateT       state, nextState;
  logic [DOWN_W-1:0] downCnt, nextDownCnt;
  logic              stallInc, flushInc;
  logic              luHaz, brTaken;
  logic [1:0]        fwdA, fwdB;

  fwd_select fwdSelA (
    .exSrc       (ex_rs),
    .memRegWrite (mem_regWrite),
    .memRd       (mem_rd),
    .wbRegWrite  (wb_regWrite),
    .wbRd        (wb_rd),
    .fwdSel      (fwdA)
  );

  fwd_select fwdSelB (
    .exSrc       (ex_rt),
    .memRegWrite (mem_regWrite),
    .memRd       (mem_rd),
    .wbRegWrite  (wb_regWrite),
    .wbRd        (wb_rd),
    .fwdSel      (fwdB)
  );

  assign saidaAfw = reset ? FWD_REG : fwdA;
  assign saidaBfw = reset ? FWD_REG : fwdB;
  assign state_o  = state;

  assign luHaz   = ex_memRead && (ex_rd != REG_ZERO) &&
                   ((ex_rd == id_rs) || (id_usesRt && (ex_rd == id_rt)));
  assign brTaken = ex_branch && zeroEx;

  // Next-state and control decode; a taken branch outranks everything, reset forces pass-through.
  always_comb begin
    nextState   = state;
    nextDownCnt = downCnt;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    ifidFlush   = 1'b0;
    idexBubble  = 1'b0;
    pcSrc       = 1'b0;
    stallInc    = 1'b0;
    flushInc    = 1'b0;
    if ((state != RUN) && (state != STALL) && (state != FLUSH)) begin
      nextState   = RUN;
      nextDownCnt = '0;
    end else if (brTaken) begin
      pcSrc      = 1'b1;
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
      flushInc   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        nextState   = FLUSH;
        nextDownCnt = DOWN_W'(FLUSH_CYCLES - 1);
      end else begin
        nextState   = RUN;
        nextDownCnt = '0;
      end
    end else begin
      case (state)
        STALL: begin
          pcWrite     = 1'b0;
          ifidWrite   = 1'b0;
          idexBubble  = 1'b1;
          stallInc    = 1'b1;
          nextDownCnt = downCnt - DOWN_W'(1);
          if (downCnt <= DOWN_W'(1)) nextState = RUN;
        end
        FLUSH: begin
          ifidFlush   = 1'b1;
          idexBubble  = 1'b1;
          nextDownCnt = downCnt - DOWN_W'(1);
          if (downCnt <= DOWN_W'(1)) nextState = RUN;
        end
        default: begin
          if (luHaz) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
            stallInc   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              nextState   = STALL;
              nextDownCnt = DOWN_W'(LOAD_STALL_CYCLES - 1);
            end
          end
        end
      endcase
    end
    if (reset) begin
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      ifidFlush  = 1'b0;
      idexBubble = 1'b0;
      pcSrc      = 1'b0;
      stallInc   = 1'b0;
      flushInc   = 1'b0;
    end
  end

  // State, down-counter and saturating event counters; reset aborts any stall or flush at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      downCnt    <= '0;
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      state   <= nextState;
      downCnt <= nextDownCnt;
      if (stallInc && (stallCount != '1)) stallCount <= stallCount + CNT_W'(1);
      if (flushInc && (flushCount != '1)) flushCount <= flushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two configurations share stimulus and are checked against a cycle model.
module tb_hazard_control_unit;

  logic       clock, reset;
  logic [4:0] idRs, idRt, exRs, exRt, exRd, memRd, wbRd;
  logic       idUsesRt, exMemRead, exBranch, zeroEx, memRegWrite, wbRegWrite;

  logic [1:0]  afw0, bfw0, state0, afw1, bfw1, state1;
  logic        pcWrite0, ifidWrite0, ifidFlush0, idexBubble0, pcSrc0;
  logic        pcWrite1, ifidWrite1, ifidFlush1, idexBubble1, pcSrc1;
  logic [15:0] stallCount0, flushCount0;
  logic [3:0]  stallCount1, flushCount1;

  int checks = 0;
  int errors = 0;

  // Model: remaining bubble / flush cycles and event counts, per configuration.
  int lsCyc[2] = '{1, 3};
  int flCyc[2] = '{1, 2};
  int cMax[2]  = '{65535, 15};
  int stallLeft[2], flushLeft[2], sCnt[2], fCnt[2];
  int nxStall[2], nxFlush[2], nxS[2], nxF[2];

  hazard_control_unit dut0 (
    .clock(clock), .reset(reset), .id_rs(idRs), .id_rt(idRt), .id_usesRt(idUsesRt),
    .ex_rs(exRs), .ex_rt(exRt), .ex_memRead(exMemRead), .ex_rd(exRd), .ex_branch(exBranch),
    .zeroEx(zeroEx), .mem_regWrite(memRegWrite), .mem_rd(memRd), .wb_regWrite(wbRegWrite),
    .wb_rd(wbRd), .saidaAfw(afw0), .saidaBfw(bfw0), .pcWrite(pcWrite0), .ifidWrite(ifidWrite0),
    .ifidFlush(ifidFlush0), .idexBubble(idexBubble0), .pcSrc(pcSrc0), .state_o(state0),
    .stallCount(stallCount0), .flushCount(flushCount0)
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .id_rs(idRs), .id_rt(idRt), .id_usesRt(idUsesRt),
    .ex_rs(exRs), .ex_rt(exRt), .ex_memRead(exMemRead), .ex_rd(exRd), .ex_branch(exBranch),
    .zeroEx(zeroEx), .mem_regWrite(memRegWrite), .mem_rd(memRd), .wb_regWrite(wbRegWrite),
    .wb_rd(wbRd), .saidaAfw(afw1), .saidaBfw(bfw1), .pcWrite(pcWrite1), .ifidWrite(ifidWrite1),
    .ifidFlush(ifidFlush1), .idexBubble(idexBubble1), .pcSrc(pcSrc1), .state_o(state1),
    .stallCount(stallCount1), .flushCount(flushCount1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [1:0] fwdCode(input logic [4:0] src);
    if (memRegWrite && memRd != 0 && memRd == src) return 2'b10;
    if (wbRegWrite && wbRd != 0 && wbRd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int satInc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Expected outputs for configuration k this cycle, plus the model's values after the next edge.
  task automatic modelStep(input int k, output logic [10:0] exp);
    logic br, lu, pw, iw, ifl, bub, ps;
    logic [1:0] st;
    br = exBranch && zeroEx;
    lu = exMemRead && exRd != 0 && (exRd == idRs || (idUsesRt && exRd == idRt));
    st = (stallLeft[k] > 0) ? 2'd1 : (flushLeft[k] > 0) ? 2'd2 : 2'd0;
    pw = 1; iw = 1; ifl = 0; bub = 0; ps = 0;
    nxStall[k] = stallLeft[k]; nxFlush[k] = flushLeft[k]; nxS[k] = sCnt[k]; nxF[k] = fCnt[k];
    if (reset) begin
      nxStall[k] = 0; nxFlush[k] = 0; nxS[k] = 0; nxF[k] = 0; st = 2'd0;
    end else if (br) begin
      ps = 1; ifl = 1; bub = 1;
      nxF[k] = satInc(fCnt[k], cMax[k]);
      nxStall[k] = 0; nxFlush[k] = flCyc[k] - 1;
    end else if (st == 2'd1) begin
      pw = 0; iw = 0; bub = 1;
      nxS[k] = satInc(sCnt[k], cMax[k]);
      nxStall[k] = stallLeft[k] - 1;
    end else if (st == 2'd2) begin
      ifl = 1; bub = 1;
      nxFlush[k] = flushLeft[k] - 1;
    end else if (lu) begin
      pw = 0; iw = 0; bub = 1;
      nxS[k] = satInc(sCnt[k], cMax[k]);
      nxStall[k] = lsCyc[k] - 1;
    end
    exp = reset ? {4'b0000, 5'b11000, st} : {fwdCode(exRs), fwdCode(exRt), pw, iw, ifl, bub, ps, st};
  endtask

  // Every negedge: compare both DUTs' outputs and counters against the model.
  always @(negedge clock) begin
    logic [10:0] exp, got;
    int dutS, dutF;
    for (int k = 0; k < 2; k++) begin
      modelStep(k, exp);
      got  = (k == 0) ? {afw0, bfw0, pcWrite0, ifidWrite0, ifidFlush0, idexBubble0, pcSrc0, state0}
                      : {afw1, bfw1, pcWrite1, ifidWrite1, ifidFlush1, idexBubble1, pcSrc1, state1};
      dutS = (k == 0) ? int'(stallCount0) : int'(stallCount1);
      dutF = (k == 0) ? int'(flushCount0) : int'(flushCount1);
      checks += 3;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL outputs dut%0d t=%0t got=%b expected=%b", k, $time, got, exp);
      end
      if (dutS != sCnt[k]) begin
        errors++;
        $display("[TB] FAIL stallCount dut%0d t=%0t got=%0d expected=%0d", k, $time, dutS, sCnt[k]);
      end
      if (dutF != fCnt[k]) begin
        errors++;
        $display("[TB] FAIL flushCount dut%0d t=%0t got=%0d expected=%0d", k, $time, dutF, fCnt[k]);
      end
    end
  end

  // Advance the model on the clock edge; reset clears it immediately.
  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        stallLeft[k] <= 0; flushLeft[k] <= 0; sCnt[k] <= 0; fCnt[k] <= 0;
      end else begin
        stallLeft[k] <= nxStall[k]; flushLeft[k] <= nxFlush[k];
        sCnt[k] <= nxS[k]; fCnt[k] <= nxF[k];
      end
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  task automatic setIdle();
    idRs = 5'd1; idRt = 5'd2; idUsesRt = 1'b1; exRs = 5'd0; exRt = 5'd0;
    exMemRead = 1'b0; exRd = 5'd0; exBranch = 1'b0; zeroEx = 1'b0;
    memRegWrite = 1'b0; memRd = 5'd0; wbRegWrite = 1'b0; wbRd = 5'd0;
  endtask

  task automatic setLoadUse();
    exMemRead = 1'b1; exRd = 5'd5; idRs = 5'd5;
  endtask

  task automatic applyStimulus();
    idRs = 5'($urandom_range(0, 3)); idRt = 5'($urandom_range(0, 3));
    idUsesRt = 1'($urandom_range(0, 1));
    exRs = 5'($urandom_range(0, 3)); exRt = 5'($urandom_range(0, 3));
    exRd = 5'($urandom_range(0, 3)); exMemRead = ($urandom_range(0, 2) == 0);
    exBranch = ($urandom_range(0, 5) == 0); zeroEx = 1'($urandom_range(0, 1));
    memRd = 5'($urandom_range(0, 3)); memRegWrite = 1'($urandom_range(0, 1));
    wbRd = 5'($urandom_range(0, 3)); wbRegWrite = 1'($urandom_range(0, 1));
  endtask

  task automatic waitCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    setIdle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checkOutput("resetStallCount0", int'(stallCount0), 0);
    checkOutput("resetState1", int'(state1), 0);
    checkOutput("resetPcWrite0", int'(pcWrite0), 1);

    // Forwarding priority and register zero.
    waitCycle();
    exRs = 5'd3; memRd = 5'd3; memRegWrite = 1'b1; wbRd = 5'd3; wbRegWrite = 1'b1;
    #1 checkOutput("fwdMemWins", int'(afw0), 2);
    memRegWrite = 1'b0;
    #1 checkOutput("fwdWb", int'(afw0), 1);
    exRs = 5'd0; memRd = 5'd0; memRegWrite = 1'b1; exRt = 5'd3;
    #1 checkOutput("fwdZeroReg", int'(afw0), 0);
    checkOutput("fwdBWb", int'(bfw1), 1);

    // Branch outranks a simultaneous load-use hazard.
    waitCycle();
    setIdle(); setLoadUse(); exBranch = 1'b1; zeroEx = 1'b1;
    #1 checkOutput("brPcSrc0", int'(pcSrc0), 1);
    checkOutput("brFlush0", int'(ifidFlush0), 1);
    checkOutput("brPcWrite0", int'(pcWrite0), 1);
    checkOutput("brPcSrc1", int'(pcSrc1), 1);
    waitCycle();
    setIdle();
    #1 checkOutput("flushState1", int'(state1), 2);
    checkOutput("flushIfid1", int'(ifidFlush1), 1);
    checkOutput("flushPcSrc1", int'(pcSrc1), 0);
    checkOutput("brFlushCount0", int'(flushCount0), 1);
    checkOutput("brStallCount0", int'(stallCount0), 0);
    waitCycle();
    checkOutput("afterFlushState1", int'(state1), 0);

    // Single load-use pulse: one bubble on dut0, three on dut1.
    setLoadUse();
    #1 checkOutput("luPcWrite0", int'(pcWrite0), 0);
    checkOutput("luIfidWrite0", int'(ifidWrite0), 0);
    checkOutput("luBubble0", int'(idexBubble0), 1);
    checkOutput("luState1a", int'(state1), 0);
    waitCycle();
    setIdle();
    #1 checkOutput("luRelease0", int'(pcWrite0 & ifidWrite0), 1);
    checkOutput("luStallCount0", int'(stallCount0), 1);
    checkOutput("luState1b", int'(state1), 1);
    checkOutput("luPcWrite1", int'(pcWrite1), 0);
    waitCycle();
    checkOutput("luState1c", int'(state1), 1);
    waitCycle();
    checkOutput("luState1d", int'(state1), 0);
    checkOutput("luStallCount1", int'(stallCount1), 3);

    // Asynchronous reset in the middle of a stall.
    setLoadUse();
    waitCycle();
    setIdle();
    #2 reset = 1'b1;
    #1 checkOutput("rstPcWrite1", int'(pcWrite1), 1);
    checkOutput("rstBubble1", int'(idexBubble1), 0);
    checkOutput("rstState1", int'(state1), 0);
    checkOutput("rstStallCount1", int'(stallCount1), 0);
    checkOutput("rstFlushCount1", int'(flushCount1), 0);
    checkOutput("rstStallCount0", int'(stallCount0), 0);
    setLoadUse();
    #1 checkOutput("rstGatePcWrite0", int'(pcWrite0), 1);
    @(posedge clock);
    #1 reset = 1'b0;
    setIdle();

    // Saturation: hold a load-use hazard for 20 cycles.
    waitCycle();
    setLoadUse();
    repeat (20) waitCycle();
    checkOutput("satStallCount1", int'(stallCount1), 15);
    checkOutput("satStallCount0", int'(stallCount0), 20);
    setIdle();
    repeat (4) waitCycle();
    exMemRead = 1'b1; exRd = 5'd7; idRt = 5'd7; idRs = 5'd2; idUsesRt = 1'b0;
    #1 checkOutput("rtOnlyPcWrite0", int'(pcWrite0), 1);
    checkOutput("rtOnlyBubble1", int'(idexBubble1), 0);
    idUsesRt = 1'b1;
    #1 checkOutput("rtUsedPcWrite0", int'(pcWrite0), 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      waitCycle();
      applyStimulus();
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
      end
    end

    waitCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
